// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32-entry integer register file with one write-back port and
// two combinational read ports.
//
// After reset an internal sequencer zeroes entries 1..31, one per clock, before
// writes are accepted. Entry 0 is hard-wired to zero and has no storage. A
// same-cycle write-back value is bypassed to any read port that addresses it.
//
// Ports:
//   clk       - single clock, all state updates on the rising edge
//   reset     - synchronous, active-high reset; restarts the clear sequence
//   rs1_addr  - read port A index
//   rs1_data  - read port A data (combinational)
//   rs2_addr  - read port B index
//   rs2_data  - read port B data (combinational)
//   wr_valid  - write-back request
//   wr_ready  - file accepts a write this cycle (high only once running)
//   wr_addr   - write index
//   wr_data   - write data
//   busy      - clear sequence in progress (reads return 0)

module regfile_2r1w #(
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] rs1_addr,
    output logic [DATA_BITS-1:0] rs1_data,
    input  logic [ADDR_BITS-1:0] rs2_addr,
    output logic [DATA_BITS-1:0] rs2_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 busy
);

    localparam int unsigned NumRegs = 1 << ADDR_BITS;

    typedef enum logic [0:0] {
        StClear,
        StRun
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] clear_idx_q, clear_idx_d;

    // Entries 1..NumRegs-1 only; x0 reads as a constant zero.
    logic [DATA_BITS-1:0] regs_q [1:NumRegs-1];

    logic                 we;
    logic [ADDR_BITS-1:0] waddr;
    logic [DATA_BITS-1:0] wdata;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StClear;
            clear_idx_q <= ADDR_BITS'(1);
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        unique case (state_q)
            StClear: begin
                // Exit is taken at the last index, so clear_idx never wraps.
                if (clear_idx_q == {ADDR_BITS{1'b1}}) begin
                    state_d = StRun;
                end else begin
                    clear_idx_d = clear_idx_q + ADDR_BITS'(1);
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    // Reset is folded in so a write presented on a reset edge never handshakes.
    assign busy     = (state_q == StClear) || reset;
    assign wr_ready = (state_q == StRun) && !reset;

    // ------------------------------------------------------------------
    // Write path: the clear sequencer and the write-back port share one port
    // ------------------------------------------------------------------
    always_comb begin
        we    = 1'b0;
        waddr = wr_addr;
        wdata = wr_data;
        if (state_q == StClear) begin
            we    = 1'b1;
            waddr = clear_idx_q;
            wdata = '0;
        end else begin
            we = wr_valid && (wr_addr != '0);
        end
    end

    // Storage has no reset; the clear sequence makes it X-free before any read.
    always_ff @(posedge clk) begin
        for (int i = 1; i < NumRegs; i++) begin
            if (!reset && we && (waddr == ADDR_BITS'(i))) begin
                regs_q[i] <= wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports with same-cycle write-back bypass
    // ------------------------------------------------------------------
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (!busy) begin
            for (int i = 1; i < NumRegs; i++) begin
                if (rs1_addr == ADDR_BITS'(i)) begin
                    rs1_data = regs_q[i];
                end
                if (rs2_addr == ADDR_BITS'(i)) begin
                    rs2_data = regs_q[i];
                end
            end
            if (wr_valid && (wr_addr == rs1_addr) && (rs1_addr != '0)) begin
                rs1_data = wr_data;
            end
            if (wr_valid && (wr_addr == rs2_addr) && (rs2_addr != '0)) begin
                rs2_data = wr_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed scenarios followed by random
// traffic, with expectations queued by the driver and compared by a monitor.

module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr;
    logic [31:0] rs1_data, rs2_data, wr_data;
    logic        wr_valid, wr_ready, busy;

    always #5 clk = ~clk;

    regfile_2r1w #(
        .DATA_BITS (32),
        .ADDR_BITS (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1_addr),
        .rs1_data (rs1_data),
        .rs2_addr (rs2_addr),
        .rs2_data (rs2_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    typedef struct {
        int          tnum;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ebusy;
        logic        erdy;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;

    // Reference model: architectural contents plus edges left in the clear.
    logic [31:0] mem [32];
    int          clear_left = 31;

    task automatic check(input string name, input int tnum, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s (test %0d): got %h, required %h", name, tnum, act, req);
    endtask

    function automatic logic [31:0] ref_read(input logic r, input logic wv,
                                             input logic [4:0] wa, input logic [31:0] wd,
                                             input logic [4:0] a);
        if (r || clear_left > 0) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (wv && wa == a) return wd;
        return mem[a];
    endfunction

    // Drive one cycle of inputs, queue the expected outputs, then advance the model.
    task automatic step(input logic r, input logic wv, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                        input int tn);
        exp_t e;
        reset = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
        rs1_addr = a1; rs2_addr = a2;
        e.tnum  = tn;
        e.e1    = ref_read(r, wv, wa, wd, a1);
        e.e2    = ref_read(r, wv, wa, wd, a2);
        e.ebusy = r || (clear_left > 0);
        e.erdy  = !e.ebusy;
        sb_q.push_back(e);
        @(posedge clk);
        if (r) begin
            clear_left = 31;
        end else if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        end else if (wv && wa != 5'd0) begin
            mem[wa] = wd;
        end
        #1;
    endtask

    // Step while the DUT reports busy and return how many edges that took.
    task automatic run_clear(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                             input logic [4:0] a1, input logic [4:0] a2, input int tn,
                             output int n);
        n = 0;
        while (busy && n < 60) begin
            step(1'b0, wv, wa, wd, a1, a2, tn);
            n++;
        end
    endtask

    // Monitor: outputs are settled by the falling edge of each driven cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("rs1_data", mon_e.tnum, rs1_data, mon_e.e1);
            check("rs2_data", mon_e.tnum, rs2_data, mon_e.e2);
            check("busy", mon_e.tnum, {31'b0, busy}, {31'b0, mon_e.ebusy});
            check("wr_ready", mon_e.tnum, {31'b0, wr_ready}, {31'b0, mon_e.erdy});
        end
    end

    initial begin
        int n;
        int waits;
        reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rs1_addr = '0; rs2_addr = '0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        @(posedge clk);
        #1;

        // 1: reset, then exactly 31 busy edges
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1);
        run_clear(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1, n);
        check("clear_edges_t1", 1, n, 31);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1);

        // 2: bypass, then storage
        step(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0, 2);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 2);

        // 3: x0 write is discarded
        step(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 3);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 3);

        // 4: back-to-back writes, dual-port bypass
        step(1'b0, 1'b1, 5'd3, 32'h11, 5'd0, 5'd0, 4);
        step(1'b0, 1'b1, 5'd4, 32'h22, 5'd0, 5'd0, 4);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 4);
        step(1'b0, 1'b1, 5'd3, 32'h33, 5'd3, 5'd3, 4);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 4);

        // 5: reset in RUN drops the same-edge write and re-clears
        step(1'b0, 1'b1, 5'd10, 32'hAA, 5'd10, 5'd0, 5);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd0, 5);
        step(1'b1, 1'b1, 5'd10, 32'hBB, 5'd10, 5'd10, 5);
        run_clear(1'b0, 5'd0, 32'h0, 5'd10, 5'd10, 5, n);
        check("clear_edges_t5", 5, n, 31);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd10, 5);

        // 6: reset mid-CLEAR restarts; a held write lands on the first RUN edge
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 6);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0, 6);
        step(1'b1, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0, 6);
        run_clear(1'b1, 5'd9, 32'h99, 5'd9, 5'd0, 6, n);
        check("clear_edges_t6", 6, n, 31);
        step(1'b0, 1'b1, 5'd9, 32'h99, 5'd0, 5'd9, 6);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 6);

        // 7: random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic [4:0] wa, a1, a2;
            r  = ($urandom_range(0, 199) == 0);
            wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
            step(r, 1'($urandom_range(0, 1)), wa, $urandom, a1, a2, 7);
        end
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 7);

        waits = 0;
        while (sb_q.size() > 0 && waits < 10) begin
            @(posedge clk);
            waits++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
